// File: rtl/matrix_result_streamer_pkg.sv
// Shared types and helpers for the matrix result streamer: the FSM state
// enum and the index-width helper used for the row/column counters.
`include "defines.sv"

package matrix_result_streamer_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } streamState_t;

    // Index width for a dimension, never narrower than one bit.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_ROW_W = idxWidth(`N_ROWS);
    localparam int DEF_COL_W = idxWidth(`N_COLUMNS);

endpackage

// File: rtl/defines.sv
// Default matrix dimensions and element width for the matrix result streamer.
// Guarded so any number of files may pull it in.
`ifndef MATRIX_STREAMER_DEFINES_SV
`define MATRIX_STREAMER_DEFINES_SV

`ifndef N_ROWS
`define N_ROWS 2
`endif

`ifndef N_COLUMNS
`define N_COLUMNS 2
`endif

`ifndef WIDTH
`define WIDTH 8
`endif

`endif

// File: rtl/matrix_result_streamer.sv
// Matrix result streamer: captures a whole result matrix in one cycle and
// streams its elements in row-major order over a valid/ready handshake.
// A matrix offered while streaming is dropped and flagged on overrun_o.
// Optional feature macro: MATRIX_STREAMER_LAST_EN adds last_o, which marks
// the final element of each matrix.
`include "defines.sv"

module matrix_result_streamer
    import matrix_result_streamer_pkg::*;
#(
    parameter int N_ROWS    = `N_ROWS,
    parameter int N_COLUMNS = `N_COLUMNS,
    parameter int WIDTH     = `WIDTH,
    parameter int C_WIDTH   = (2 * WIDTH) * $clog2(N_ROWS),
    localparam int ROW_W    = idxWidth(N_ROWS),
    localparam int COL_W    = idxWidth(N_COLUMNS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    input  logic [C_WIDTH-1:0] c_i [N_ROWS][N_COLUMNS],
    output logic               ready_o,
    output logic [C_WIDTH-1:0] data_o,
    output logic [ROW_W-1:0]   row_o,
    output logic [COL_W-1:0]   col_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               overrun_o,
`ifdef MATRIX_STREAMER_LAST_EN
    output logic               last_o,
`endif
    input  logic               overrun_clr_i
);

    streamState_t       r_state;
    streamState_t       w_nextState;
    logic [C_WIDTH-1:0] r_buf [N_ROWS][N_COLUMNS];
    logic [ROW_W-1:0]   r_row;
    logic [COL_W-1:0]   r_col;
    logic               r_overrun;
    logic               w_handshake;
    logic               w_isLast;
    logic               w_capture;
    logic               w_drop;

    assign w_isLast    = (r_row == ROW_W'(N_ROWS - 1)) && (r_col == COL_W'(N_COLUMNS - 1));
    assign w_handshake = (r_state == STREAM) && ready_i;
    assign w_capture   = (r_state == IDLE) && valid_i;
    assign w_drop      = (r_state == STREAM) && valid_i;

    assign data_o    = r_buf[r_row][r_col];
    assign row_o     = r_row;
    assign col_o     = r_col;
    assign overrun_o = r_overrun;

`ifdef MATRIX_STREAMER_LAST_EN
    assign last_o = valid_o && w_isLast;
`endif

    // State register; reset aborts any matrix in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and the handshake outputs, which depend on state only.
    always_comb begin
        w_nextState = r_state;
        ready_o     = 1'b0;
        valid_o     = 1'b0;
        case (r_state)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    w_nextState = STREAM;
                end
            end
            STREAM: begin
                valid_o = 1'b1;
                if (w_handshake && w_isLast) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Matrix buffer and row/column cursor: load on capture, step on handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf <= '{default: '0};
            r_row <= '0;
            r_col <= '0;
        end else if (w_capture) begin
            r_buf <= c_i;
            r_row <= '0;
            r_col <= '0;
        end else if (w_handshake) begin
            if (r_col == COL_W'(N_COLUMNS - 1)) begin
                r_col <= '0;
                r_row <= (r_row == ROW_W'(N_ROWS - 1)) ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Sticky overrun flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr_i) begin
            r_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Testbench for matrix_result_streamer with a 2x2 matrix of 16-bit results.
// When MATRIX_STREAMER_LAST_EN is defined, last_o is also connected and checked.
module tb_matrix_result_streamer;

   localparam int NR = 2;
   localparam int NC = 2;
   localparam int W  = 8;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid_i;
   logic [CW-1:0] c_i [NR][NC];
   logic          ready_o;
   logic [CW-1:0] data_o;
   logic          row_o;
   logic          col_o;
   logic          valid_o;
   logic          ready_i;
   logic          overrun_o;
   logic          overrun_clr_i;
`ifdef MATRIX_STREAMER_LAST_EN
   logic          last_o;
`endif

   int total = 0;
   int bad   = 0;

   matrix_result_streamer #(
      .N_ROWS(NR),
      .N_COLUMNS(NC),
      .WIDTH(W),
      .C_WIDTH(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .valid_i(valid_i),
      .c_i(c_i),
      .ready_o(ready_o),
      .data_o(data_o),
      .row_o(row_o),
      .col_o(col_o),
      .valid_o(valid_o),
      .ready_i(ready_i),
      .overrun_o(overrun_o),
`ifdef MATRIX_STREAMER_LAST_EN
      .last_o(last_o),
`endif
      .overrun_clr_i(overrun_clr_i)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // One comparison: count it, and report it if the DUT disagrees.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive the handshake inputs for the coming clock edge.
   task automatic applyStimulus(input logic v, input logic r, input logic clr);
      valid_i       = v;
      ready_i       = r;
      overrun_clr_i = clr;
   endtask

   // Load the matrix presented on c_i.
   task automatic setMatrix(input logic [CW-1:0] a, input logic [CW-1:0] b,
                            input logic [CW-1:0] c, input logic [CW-1:0] d);
      c_i[0][0] = a;
      c_i[0][1] = b;
      c_i[1][0] = c;
      c_i[1][1] = d;
   endtask

   // Expect a streamed element with the given value and position.
   task automatic expectElem(input string tag, input logic [CW-1:0] d, input logic r, input logic c);
      checkOutput({tag, " valid"}, 32'(valid_o), 32'd1);
      checkOutput({tag, " ready"}, 32'(ready_o), 32'd0);
      checkOutput({tag, " data"},  32'(data_o),  32'(d));
      checkOutput({tag, " row"},   32'(row_o),   32'(r));
      checkOutput({tag, " col"},   32'(col_o),   32'(c));
`ifdef MATRIX_STREAMER_LAST_EN
      checkOutput({tag, " last"},  32'(last_o),  32'((r == 1'b1) && (c == 1'b1)));
`endif
   endtask

   // Expect the idle condition: nothing streaming, ready for a new matrix.
   task automatic expectIdle(input string tag);
      checkOutput({tag, " valid"}, 32'(valid_o), 32'd0);
      checkOutput({tag, " ready"}, 32'(ready_o), 32'd1);
   endtask

   // Reset the DUT with quiet inputs and check the reset values.
   task automatic doReset();
      applyStimulus(1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      #3;
      checkOutput("reset valid",   32'(valid_o),   32'd0);
      checkOutput("reset overrun", 32'(overrun_o), 32'd0);
      checkOutput("reset data",    32'(data_o),    32'd0);
      checkOutput("reset row",     32'(row_o),     32'd0);
      checkOutput("reset col",     32'(col_o),     32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      expectIdle("after reset");
   endtask

   // ------------------------------------------------------------------
   // Reference model: a queue of elements still owed downstream. A capture
   // enqueues the whole matrix in row-major order; a handshake pops one.
   // ------------------------------------------------------------------
   typedef struct {
      logic [CW-1:0] d;
      logic          r;
      logic          c;
   } elem_t;

   elem_t mq[$];
   logic  mOvr;

   task automatic modelReset();
      mq.delete();
      mOvr = 1'b0;
   endtask

   // Compare DUT outputs against what the model says should be visible now.
   task automatic modelCheck();
      checkOutput("model ready",   32'(ready_o),   32'(mq.size() == 0));
      checkOutput("model valid",   32'(valid_o),   32'(mq.size() != 0));
      checkOutput("model overrun", 32'(overrun_o), 32'(mOvr));
      if (mq.size() != 0) begin
         checkOutput("model data", 32'(data_o), 32'(mq[0].d));
         checkOutput("model row",  32'(row_o),  32'(mq[0].r));
         checkOutput("model col",  32'(col_o),  32'(mq[0].c));
`ifdef MATRIX_STREAMER_LAST_EN
         checkOutput("model last", 32'(last_o), 32'(mq[0].r == 1'b1 && mq[0].c == 1'b1));
`endif
      end
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic modelAdvance();
      logic busy;
      elem_t e;
      busy = (mq.size() != 0);
      if (busy && valid_i) mOvr = 1'b1;
      else if (overrun_clr_i) mOvr = 1'b0;
      if (busy && ready_i) begin
         void'(mq.pop_front());
      end else if (!busy && valid_i) begin
         for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) begin
               e.d = c_i[r][c];
               e.r = 1'(r);
               e.c = 1'(c);
               mq.push_back(e);
            end
         end
      end
   endtask

   // ------------------------------------------------------------------
   // Directed table: inputs applied this cycle plus outputs expected this
   // cycle (all outputs are registered, so current inputs do not affect them).
   // ------------------------------------------------------------------
   typedef struct {
      logic          vIn;
      logic          rIn;
      logic          expReady;
      logic          expValid;
      logic [CW-1:0] expData;
      logic          expRow;
      logic          expCol;
   } vector_t;

   vector_t vecs [15];

   initial begin
      // Back-to-back streaming, then the same matrix with ready_i toggling.
      vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd1, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 1'b0, 1'b1};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd3, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd4, 1'b1, 1'b1};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd1, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd3, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd3, 1'b1, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd4, 1'b1, 1'b1};
      vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd4, 1'b1, 1'b1};
      vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0};

      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      setMatrix(16'd0, 16'd0, 16'd0, 16'd0);
      @(negedge clk);
      doReset();

      // Table-driven run of the two directed streams.
      setMatrix(16'd1, 16'd2, 16'd3, 16'd4);
      for (int i = 0; i < 15; i++) begin
         checkOutput($sformatf("vec%0d ready", i), 32'(ready_o), 32'(vecs[i].expReady));
         checkOutput($sformatf("vec%0d valid", i), 32'(valid_o), 32'(vecs[i].expValid));
         if (vecs[i].expValid) begin
            checkOutput($sformatf("vec%0d data", i), 32'(data_o), 32'(vecs[i].expData));
            checkOutput($sformatf("vec%0d row", i),  32'(row_o),  32'(vecs[i].expRow));
            checkOutput($sformatf("vec%0d col", i),  32'(col_o),  32'(vecs[i].expCol));
`ifdef MATRIX_STREAMER_LAST_EN
            checkOutput($sformatf("vec%0d last", i), 32'(last_o), 32'(vecs[i].expData == 16'd4));
`endif
         end
         applyStimulus(vecs[i].vIn, vecs[i].rIn, 1'b0);
         @(negedge clk);
      end

      // Overrun: a matrix offered mid-stream is dropped and the flag sets.
      applyStimulus(1'b1, 1'b1, 1'b0);
      @(negedge clk);
      expectElem("ovr e1", 16'd1, 1'b0, 1'b0);
      setMatrix(16'd9, 16'd9, 16'd9, 16'd9);
      applyStimulus(1'b1, 1'b1, 1'b0);
      @(negedge clk);
      expectElem("ovr e2", 16'd2, 1'b0, 1'b1);
      checkOutput("ovr set", 32'(overrun_o), 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      expectElem("ovr e3", 16'd3, 1'b1, 1'b0);
      @(negedge clk);
      expectElem("ovr e4", 16'd4, 1'b1, 1'b1);
      @(negedge clk);
      expectIdle("ovr idle");
      checkOutput("ovr sticky", 32'(overrun_o), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("ovr cleared", 32'(overrun_o), 32'd0);

      // Drop and clear in the same cycle: set must win.
      setMatrix(16'd1, 16'd2, 16'd3, 16'd4);
      applyStimulus(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      expectElem("both e1", 16'd1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      @(negedge clk);
      expectElem("both hold", 16'd1, 1'b0, 1'b0);
      checkOutput("both set wins", 32'(overrun_o), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("both then clear", 32'(overrun_o), 32'd0);

      // Reset in the middle of the stream, right after the 2nd element.
      applyStimulus(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      expectElem("rst e2", 16'd2, 1'b0, 1'b1);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("rst async valid", 32'(valid_o), 32'd0);
      checkOutput("rst async data",  32'(data_o),  32'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         expectIdle($sformatf("rst quiet%0d", i));
      end

      // Randomized traffic checked against the queue model.
      doReset();
      modelReset();
      for (int i = 0; i < 800; i++) begin
         modelCheck();
         if ($urandom_range(0, 3) == 0) begin
            setMatrix(CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom));
         end
         applyStimulus(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 6),
                       ($urandom_range(0, 9) == 0));
         modelAdvance();
         @(negedge clk);
      end
      modelCheck();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/matrix_result_streamer.md
MATRIX_RESULT_STREAMER -- requirements
Module: matrix_result_streamer

Interface
REQ-001 SHALL have parameter N_ROWS, default `N_ROWS: number of matrix rows.
REQ-002 SHALL have parameter N_COLUMNS, default `N_COLUMNS: number of matrix columns.
REQ-003 SHALL have parameter WIDTH, default `WIDTH: operand element width.
REQ-004 SHALL have parameter C_WIDTH, default (2*WIDTH)*$clog2(N_ROWS): result element width.
REQ-005 SHALL have port clk, input, 1: clock, all state on rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port valid_i, input, 1: result matrix on c_i is valid this cycle.
REQ-008 SHALL have port c_i, input, [C_WIDTH-1:0] x [N_ROWS][N_COLUMNS]: result matrix from the multiplier.
REQ-009 SHALL have port ready_o, input-side status, output, 1: high when a new matrix can be captured.
REQ-010 SHALL have port data_o, output, C_WIDTH: current streamed element.
REQ-011 SHALL have port row_o, output, $clog2(N_ROWS) (min 1): row index of data_o.
REQ-012 SHALL have port col_o, output, $clog2(N_COLUMNS) (min 1): column index of data_o.
REQ-013 SHALL have port valid_o, output, 1: data_o/row_o/col_o valid.
REQ-014 SHALL have port ready_i, input, 1: downstream accepts element when valid_o && ready_i.
REQ-015 SHALL have port overrun_o, output, 1: sticky flag, matrix dropped.
REQ-016 SHALL have port overrun_clr_i, input, 1: synchronous clear of overrun_o.

Function
REQ-017 SHALL implement FSM with states IDLE and STREAM.
REQ-018 SHALL drive ready_o = 1 exactly when state is IDLE.
REQ-019 In IDLE with valid_i=1, SHALL capture all of c_i into an internal buffer, clear row/col counters to 0, and enter STREAM next cycle.
REQ-020 SHALL assert valid_o in STREAM only; first element visible the cycle after capture (latency 1).
REQ-021 SHALL stream elements in row-major order: (0,0),(0,1)..(0,N_COLUMNS-1),(1,0)..(N_ROWS-1,N_COLUMNS-1).
REQ-022 SHALL advance col, wrapping to 0 and incrementing row, only on valid_o && ready_i.
REQ-023 SHALL hold data_o, row_o, col_o, valid_o stable while valid_o && !ready_i.
REQ-024 On handshake of element (N_ROWS-1,N_COLUMNS-1), SHALL return to IDLE next cycle; valid_o deasserts that cycle.
REQ-025 SHALL not capture in the same cycle as the last handshake; new capture earliest one cycle later in IDLE.
REQ-026 valid_i=1 while in STREAM SHALL be dropped, buffer unchanged, overrun_o set next cycle.
REQ-027 overrun_clr_i SHALL clear overrun_o next cycle; simultaneous drop and clear: set wins.
REQ-028 Buffer, data_o, row_o, col_o SHALL be unsigned pass-through, no arithmetic on element values.

Reset
REQ-029 On rst=0, SHALL asynchronously enter IDLE, clear buffer to 0, row/col to 0, valid_o=0, overrun_o=0, data_o=0.
REQ-030 Reset mid-stream SHALL abort the matrix; no remaining elements emitted after release.
REQ-031 ready_o SHALL be 1 from the first cycle after reset release.

Configuration
REQ-032 Macro MATRIX_STREAMER_LAST_EN: when defined, SHALL add output last_o, 1 bit, high with valid_o on element (N_ROWS-1,N_COLUMNS-1) only.
REQ-033 Without MATRIX_STREAMER_LAST_EN, last_o SHALL not exist; all other behaviour identical.

Structure
REQ-034 Shared package SHALL hold state enum type (IDLE, STREAM) and index-width helper constants; dimension defaults remain in defines.sv.
REQ-035 Single module, no sub-modules; buffer and counters inline.

Verification (N_ROWS=N_COLUMNS=2, WIDTH=8, C_WIDTH=16)
REQ-036 Capture c_i={{1,2},{3,4}}, valid_i 1 cycle, ready_i=1 -> data_o 1,2,3,4 on consecutive cycles, (row,col) (0,0),(0,1),(1,0),(1,1), then IDLE, ready_o=1.
REQ-037 Same matrix, ready_i toggling 1,0,1,0 -> each element held while ready_i=0, order unchanged, exactly 4 handshakes.
REQ-038 valid_i pulsed during STREAM with c_i={{9,9},{9,9}} -> output stays 1,2,3,4, overrun_o=1 next cycle; overrun_clr_i -> overrun_o=0.
REQ-039 Drop and overrun_clr_i in same cycle -> overrun_o=1.
REQ-040 rst low after 2nd element -> valid_o=0 immediately, after release ready_o=1, no further outputs until new valid_i.
REQ-041 With MATRIX_STREAMER_LAST_EN -> last_o=1 only with data_o=4; without it, build compiles with no last_o port.
